ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand, result and PC width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; it is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, meaning a decoded instruction is offered.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the stage accepts the offer this cycle.
REQ-006 The block SHALL have ports in_pc, in_rs1_val, in_rs2_val and in_imm, input, DATA_WIDTH each, carrying the instruction address, register operands and sign-extended immediate.
REQ-007 The block SHALL have port in_alu_op, input, 5, carrying the isa_shared ALU opcode.
REQ-008 The block SHALL have ports in_src_a_pc and in_src_b_imm, input, 1 each; when set, ALU operand a = in_pc and operand b = in_imm respectively, otherwise a = rs1 and b = rs2.
REQ-009 The block SHALL have port in_br_type, input, 2, one of BR_NONE, BR_COND, BR_JAL or BR_JALR.
REQ-010 The block SHALL have ports in_rd, input, 5, and in_rd_we, input, 1, carrying the destination register and its write enable.
REQ-011 The block SHALL have port flush, input, 1, which kills the registered instruction.
REQ-012 The block SHALL have ports out_valid, output, 1, and out_ready, input, 1, forming the downstream handshake.
REQ-013 The block SHALL have ports out_result and out_pc, output, DATA_WIDTH each, plus out_rd, output, 5, and out_rd_we, output, 1.
REQ-014 The block SHALL have ports redirect_valid, output, 1, and redirect_pc, output, DATA_WIDTH, plus misaligned, output, 1.

Function
REQ-015 The block SHALL behave as a one-entry pipeline register with in_ready = !out_valid || out_ready, and in_ready held at 0 while flush is 1.
REQ-016 On accept (in_valid && in_ready), all out_* fields SHALL be captured on that edge, giving a latency of exactly 1 cycle.
REQ-017 While out_valid is 1 and out_ready is 0, all out_* fields SHALL be held stable.
REQ-018 out_valid SHALL clear on the edge where out_ready is 1 and no new instruction is accepted.
REQ-019 For BR_NONE, out_result SHALL be the ALU result on the selected operands.
REQ-020 For BR_COND, the ALU SHALL compare rs1 against rs2 using in_alu_op; taken = alu result bit 0; target = in_pc + in_imm; out_rd_we is forced to 0.
REQ-021 For BR_JAL, target = in_pc + in_imm; for BR_JALR, target = (in_rs1_val + in_imm) with bit 0 cleared; for both, out_result = in_pc + 4 and the jump is always taken.
REQ-022 The target adder SHALL be separate from the ALU, with all sums taken modulo 2^DATA_WIDTH (wrap-around, no trap); ALU overflow and carry SHALL be ignored.
REQ-023 For a taken branch or jump, redirect_valid SHALL pulse high for exactly one cycle on the cycle after accept, with redirect_pc = target.
REQ-024 A not-taken branch SHALL leave redirect_valid at 0.
REQ-025 misaligned SHALL be registered as taken && target[1:0] != 0; in that case redirect_valid stays 0 and out_rd_we is forced to 0.
REQ-026 When flush is 1, out_valid, redirect_valid and misaligned SHALL be 0 on the next edge, and no new instruction is accepted that cycle.
REQ-027 Flush SHALL take priority over simultaneous accept and simultaneous out_ready.
REQ-028 Unknown in_alu_op values SHALL yield out_result = 0.

Reset
REQ-029 While rst_n is 0, out_valid, redirect_valid, misaligned and out_rd_we SHALL be 0, and out_result, out_pc, out_rd and redirect_pc SHALL be 0, regardless of clk.
REQ-030 Reset asserted mid-transfer SHALL discard the held instruction.
REQ-031 The first accept after reset SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 The br_type enum (BR_NONE=0, BR_COND=1, BR_JAL=2, BR_JALR=3) SHALL reside in package isa_shared beside the ALU opcodes.
REQ-033 The block SHALL instantiate exactly one alu sub-module; all other logic is local to the block.

Verification
REQ-034 Directed test, ALU op: ADD with rs1=5, rs2=7, src flags 0, out_ready=1 -> next cycle out_valid=1, out_result=12, redirect_valid=0.
REQ-035 Directed test, conditional branch: BR_COND, ALU_LT, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> redirect_valid one-cycle pulse, redirect_pc=0x120, out_rd_we=0.
REQ-036 Directed test, JALR: rs1=0x1003, imm=0, pc=0x40 -> redirect_pc=0x1002, misaligned=1, redirect_valid=0, out_rd_we=0.
REQ-037 Directed test, backpressure: accept A, hold out_ready=0 for 3 cycles, offer B -> in_ready=0 and A held stable; raise out_ready -> B captured on that edge.
REQ-038 Directed test, flush versus accept: flush=1 concurrent with in_valid=1 and a taken JAL in the register -> next cycle out_valid=0 and redirect_valid=0.
REQ-039 Directed test, reset: rst_n low mid-stall, asynchronously -> all outputs 0 immediately; accept succeeds on the first edge after release.

Source files
------------

// File: rtl/isa_shared_pkg.sv
// Shared ISA encodings: ALU opcodes and branch types used by decode and execute.
package isa_shared;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_AND   = 5'd2,
        ALU_OR    = 5'd3,
        ALU_XOR   = 5'd4,
        ALU_SLL   = 5'd5,
        ALU_SRL   = 5'd6,
        ALU_SRA   = 5'd7,
        ALU_LT    = 5'd8,
        ALU_LTU   = 5'd9,
        ALU_EQ    = 5'd10,
        ALU_NE    = 5'd11,
        ALU_GE    = 5'd12,
        ALU_GEU   = 5'd13,
        ALU_PASSB = 5'd14
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JAL  = 2'd2,
        BR_JALR = 2'd3
    } br_type_e;

    // Byte distance from a jump to its return address.
    localparam int LINK_OFFSET = 4;

    function automatic logic is_jump(input br_type_e br);
        return (br == BR_JAL) || (br == BR_JALR);
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU; comparisons return 0/1 in bit 0, unknown opcodes return 0.
module alu
    import isa_shared::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [4:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    logic [SHAMT_W-1:0] shamt;
    logic               lt_s;
    logic               lt_u;
    logic               eq;

    assign shamt = b[SHAMT_W-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign eq    = a == b;

    always_comb begin
        result = '0;
        case (alu_op_e'(op))
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLL:   result = a << shamt;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_LT:    result = DATA_WIDTH'(lt_s);
            ALU_LTU:   result = DATA_WIDTH'(lt_u);
            ALU_EQ:    result = DATA_WIDTH'(eq);
            ALU_NE:    result = DATA_WIDTH'(!eq);
            ALU_GE:    result = DATA_WIDTH'(!lt_s);
            ALU_GEU:   result = DATA_WIDTH'(!lt_u);
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolution and a one-entry output register
// with valid/ready handshake, flush and a one-cycle redirect pulse.
module ex_stage
    import isa_shared::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_rs1_val,
    input  logic [DATA_WIDTH-1:0] in_rs2_val,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [4:0]            in_alu_op,
    input  logic                  in_src_a_pc,
    input  logic                  in_src_b_imm,
    input  logic [1:0]            in_br_type,
    input  logic [4:0]            in_rd,
    input  logic                  in_rd_we,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [4:0]            out_rd,
    output logic                  out_rd_we,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  misaligned
);

    br_type_e              br;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_y;
    logic [DATA_WIDTH-1:0] tgt_base;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] result;
    logic                  taken;
    logic                  misalign;
    logic                  rd_we;
    logic                  accept;

    logic                  out_valid_q,      out_valid_d;
    logic [DATA_WIDTH-1:0] out_result_q,     out_result_d;
    logic [DATA_WIDTH-1:0] out_pc_q,         out_pc_d;
    logic [4:0]            out_rd_q,         out_rd_d;
    logic                  out_rd_we_q,      out_rd_we_d;
    logic                  redirect_valid_q, redirect_valid_d;
    logic [DATA_WIDTH-1:0] redirect_pc_q,    redirect_pc_d;
    logic                  misaligned_q,     misaligned_d;

    assign br = br_type_e'(in_br_type);

    // Conditional branches always compare the two register operands.
    always_comb begin
        alu_a = in_src_a_pc  ? in_pc  : in_rs1_val;
        alu_b = in_src_b_imm ? in_imm : in_rs2_val;
        if (br == BR_COND) begin
            alu_a = in_rs1_val;
            alu_b = in_rs2_val;
        end
    end

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op     (in_alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_y)
    );

    // Dedicated target adder so the ALU stays free for the compare.
    always_comb begin
        tgt_base = (br == BR_JALR) ? in_rs1_val : in_pc;
        target   = tgt_base + in_imm;
        if (br == BR_JALR) begin
            target[0] = 1'b0;
        end
        case (br)
            BR_COND:         taken = alu_y[0];
            BR_JAL, BR_JALR: taken = 1'b1;
            default:         taken = 1'b0;
        endcase
        misalign = taken && (target[1:0] != 2'b00);
        result   = is_jump(br) ? (in_pc + DATA_WIDTH'(LINK_OFFSET)) : alu_y;
        rd_we    = in_rd_we && (br != BR_COND) && !misalign;
    end

    assign in_ready = (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d      = out_valid_q;
        out_result_d     = out_result_q;
        out_pc_d         = out_pc_q;
        out_rd_d         = out_rd_q;
        out_rd_we_d      = out_rd_we_q;
        redirect_pc_d    = redirect_pc_q;
        misaligned_d     = misaligned_q;
        redirect_valid_d = 1'b0;
        if (flush) begin
            out_valid_d  = 1'b0;
            misaligned_d = 1'b0;
        end else if (accept) begin
            out_valid_d      = 1'b1;
            out_result_d     = result;
            out_pc_d         = in_pc;
            out_rd_d         = in_rd;
            out_rd_we_d      = rd_we;
            redirect_pc_d    = target;
            misaligned_d     = misalign;
            redirect_valid_d = taken && !misalign;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
            misaligned_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            out_result_q     <= '0;
            out_pc_q         <= '0;
            out_rd_q         <= '0;
            out_rd_we_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            misaligned_q     <= 1'b0;
        end else begin
            out_valid_q      <= out_valid_d;
            out_result_q     <= out_result_d;
            out_pc_q         <= out_pc_d;
            out_rd_q         <= out_rd_d;
            out_rd_we_q      <= out_rd_we_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            misaligned_q     <= misaligned_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_pc         = out_pc_q;
    assign out_rd         = out_rd_q;
    assign out_rd_we      = out_rd_we_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for single transfers plus
// hand-written backpressure, flush and asynchronous reset sequences.
module tb_ex_stage;
    import isa_shared::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_alu_op;
    logic        in_src_a_pc, in_src_b_imm;
    logic [1:0]  in_br_type;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result, out_pc;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_stage #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_rs1_val     (in_rs1_val),
        .in_rs2_val     (in_rs2_val),
        .in_imm         (in_imm),
        .in_alu_op      (in_alu_op),
        .in_src_a_pc    (in_src_a_pc),
        .in_src_b_imm   (in_src_b_imm),
        .in_br_type     (in_br_type),
        .in_rd          (in_rd),
        .in_rd_we       (in_rd_we),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_pc         (out_pc),
        .out_rd         (out_rd),
        .out_rd_we      (out_rd_we),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misaligned     (misaligned)
    );

    typedef struct {
        logic [1:0]  br;
        logic [4:0]  op;
        logic [31:0] pc, rs1, rs2, imm;
        logic        sa, sb;
        logic [31:0] exp_result;
        logic        exp_redir;
        logic [31:0] exp_rpc;
        logic        exp_mis;
        logic        exp_rd_we;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [1:0] br, input logic [4:0] op,
                                input logic [31:0] pc, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm,
                                input logic sa, input logic sb,
                                input logic [31:0] res, input logic redir,
                                input logic [31:0] rpc, input logic mis,
                                input logic rdwe);
        vec_t v;
        v.br = br; v.op = op; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.sa = sa; v.sb = sb; v.exp_result = res; v.exp_redir = redir;
        v.exp_rpc = rpc; v.exp_mis = mis; v.exp_rd_we = rdwe;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] br, input logic [4:0] op, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic sa, input logic sb, input logic [4:0] rd);
        in_valid     = 1'b1;
        in_br_type   = br;
        in_alu_op    = op;
        in_pc        = pc;
        in_rs1_val   = rs1;
        in_rs2_val   = rs2;
        in_imm       = imm;
        in_src_a_pc  = sa;
        in_src_b_imm = sb;
        in_rd        = rd;
        in_rd_we     = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"},      32'(out_valid),      32'd0);
        check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'd0);
        check({tag, ".misaligned"},     32'(misaligned),     32'd0);
        check({tag, ".out_rd_we"},      32'(out_rd_we),      32'd0);
        check({tag, ".out_result"},     out_result,          32'd0);
        check({tag, ".out_pc"},         out_pc,              32'd0);
        check({tag, ".out_rd"},         32'(out_rd),         32'd0);
        check({tag, ".redirect_pc"},    redirect_pc,         32'd0);
    endtask

    initial begin
        //            br       op        pc            rs1           rs2           imm          sa sb result        rd rpc          mis we
        vecs[0]  = mk(BR_NONE, ALU_ADD,  32'h0,        32'd5,        32'd7,        32'h0,        0, 0, 32'd12,       0, 32'h0,       0, 1);
        vecs[1]  = mk(BR_NONE, ALU_SUB,  32'h4,        32'd5,        32'd7,        32'h0,        0, 0, 32'hFFFFFFFE, 0, 32'h0,       0, 1);
        vecs[2]  = mk(BR_NONE, ALU_AND,  32'h8,        32'hF0F0,     32'hFF00,     32'h0,        0, 0, 32'hF000,     0, 32'h0,       0, 1);
        vecs[3]  = mk(BR_NONE, ALU_OR,   32'hC,        32'hF0F0,     32'h0F0F,     32'h0,        0, 0, 32'hFFFF,     0, 32'h0,       0, 1);
        vecs[4]  = mk(BR_NONE, ALU_XOR,  32'h10,       32'hFF,       32'h0F,       32'h0,        0, 0, 32'hF0,       0, 32'h0,       0, 1);
        vecs[5]  = mk(BR_NONE, ALU_SLL,  32'h14,       32'd1,        32'd99,       32'd4,        0, 1, 32'd16,       0, 32'h0,       0, 1);
        vecs[6]  = mk(BR_NONE, ALU_SRA,  32'h18,       32'h80000000, 32'd4,        32'h0,        0, 0, 32'hF8000000, 0, 32'h0,       0, 1);
        vecs[7]  = mk(BR_NONE, ALU_SRL,  32'h1C,       32'h80000000, 32'd4,        32'h0,        0, 0, 32'h08000000, 0, 32'h0,       0, 1);
        vecs[8]  = mk(BR_NONE, ALU_LT,   32'h20,       32'hFFFFFFFF, 32'd1,        32'h0,        0, 0, 32'd1,        0, 32'h0,       0, 1);
        vecs[9]  = mk(BR_NONE, ALU_LTU,  32'h24,       32'hFFFFFFFF, 32'd1,        32'h0,        0, 0, 32'd0,        0, 32'h0,       0, 1);
        vecs[10] = mk(BR_NONE, ALU_ADD,  32'h100,      32'h0,        32'h0,        32'h20,       1, 1, 32'h120,      0, 32'h0,       0, 1);
        vecs[11] = mk(BR_NONE, 5'd31,    32'h28,       32'd5,        32'd7,        32'h0,        0, 0, 32'd0,        0, 32'h0,       0, 1);
        vecs[12] = mk(BR_NONE, ALU_ADD,  32'h2C,       32'hFFFFFFFF, 32'd2,        32'h0,        0, 0, 32'd1,        0, 32'h0,       0, 1);
        vecs[13] = mk(BR_COND, ALU_LT,   32'h100,      32'hFFFFFFFF, 32'd1,        32'h20,       1, 1, 32'd1,        1, 32'h120,     0, 0);
        vecs[14] = mk(BR_COND, ALU_EQ,   32'h100,      32'd3,        32'd4,        32'h20,       0, 0, 32'd0,        0, 32'h0,       0, 0);
        vecs[15] = mk(BR_JAL,  ALU_ADD,  32'h200,      32'h0,        32'h0,        32'h40,       0, 0, 32'h204,      1, 32'h240,     0, 1);
        vecs[16] = mk(BR_JAL,  ALU_ADD,  32'hFFFFFFF0, 32'h0,        32'h0,        32'h20,       0, 0, 32'hFFFFFFF4, 1, 32'h10,      0, 1);
        vecs[17] = mk(BR_JALR, ALU_ADD,  32'h40,       32'h1003,     32'h0,        32'h0,        0, 0, 32'h44,       0, 32'h1002,    1, 0);
        vecs[18] = mk(BR_JALR, ALU_ADD,  32'h40,       32'h1001,     32'h0,        32'h0,        0, 0, 32'h44,       1, 32'h1000,    0, 1);
        vecs[19] = mk(BR_COND, ALU_GEU,  32'h100,      32'd5,        32'd5,        32'hFFFFFFF0, 0, 0, 32'd1,        1, 32'hF0,      0, 0);
        vecs[20] = mk(BR_COND, ALU_NE,   32'h100,      32'd1,        32'd2,        32'd2,        0, 0, 32'd1,        0, 32'h102,     1, 0);
        vecs[21] = mk(BR_COND, ALU_GE,   32'h100,      32'hFFFFFFFF, 32'd1,        32'd8,        0, 0, 32'd0,        0, 32'h0,       0, 0);
        vecs[22] = mk(BR_NONE, ALU_PASSB,32'h30,       32'd1,        32'd2,        32'hABCD0000, 0, 1, 32'hABCD0000, 0, 32'h0,       0, 1);
        vecs[23] = mk(BR_JALR, ALU_ADD,  32'h40,       32'hFFFFFFFC, 32'h0,        32'h8,        0, 0, 32'h44,       1, 32'h4,       0, 1);

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(BR_NONE, ALU_ADD, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 5'd0);
        in_valid = 1'b0;

        // Outputs must be zero under reset before and after clock edges.
        #3;
        check_all_zero("reset_pre_edge");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_post_edge");
        $display("txn reset: outputs held at zero");

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].br, vecs[i].op, vecs[i].pc, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].imm, vecs[i].sa, vecs[i].sb, 5'(i + 1));
            @(posedge clk);
            #1;
            check($sformatf("v%0d.out_valid", i),  32'(out_valid), 32'd1);
            check($sformatf("v%0d.out_result", i), out_result, vecs[i].exp_result);
            check($sformatf("v%0d.out_pc", i),     out_pc, vecs[i].pc);
            check($sformatf("v%0d.out_rd", i),     32'(out_rd), 32'(i + 1));
            check($sformatf("v%0d.out_rd_we", i),  32'(out_rd_we), 32'(vecs[i].exp_rd_we));
            check($sformatf("v%0d.redirect", i),   32'(redirect_valid), 32'(vecs[i].exp_redir));
            check($sformatf("v%0d.misaligned", i), 32'(misaligned), 32'(vecs[i].exp_mis));
            if (vecs[i].exp_redir || vecs[i].exp_mis)
                check($sformatf("v%0d.redirect_pc", i), redirect_pc, vecs[i].exp_rpc);
            $display("txn v%0d: br=%0d op=%0d result=0x%08h redirect=%0b rpc=0x%08h mis=%0b rd_we=%0b",
                     i, vecs[i].br, vecs[i].op, out_result, redirect_valid, redirect_pc,
                     misaligned, out_rd_we);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("v%0d.redirect_pulse_end", i), 32'(redirect_valid), 32'd0);
            check($sformatf("v%0d.drain", i),              32'(out_valid), 32'd0);
        end

        // Backpressure: jump A stalls three cycles while B is offered.
        @(negedge clk);
        out_ready = 1'b0;
        drive(BR_JAL, ALU_ADD, 32'h300, 32'h0, 32'h0, 32'h10, 0, 0, 5'd3);
        @(posedge clk);
        #1;
        check("bp.a_valid",    32'(out_valid), 32'd1);
        check("bp.a_redirect", 32'(redirect_valid), 32'd1);
        check("bp.a_result",   out_result, 32'h304);
        @(negedge clk);
        drive(BR_NONE, ALU_ADD, 32'h304, 32'd10, 32'd20, 32'h0, 0, 0, 5'd4);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp.stall%0d.in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("bp.stall%0d.result", c),   out_result, 32'h304);
            check($sformatf("bp.stall%0d.pc", c),       out_pc, 32'h300);
            check($sformatf("bp.stall%0d.rd", c),       32'(out_rd), 32'd3);
            check($sformatf("bp.stall%0d.valid", c),    32'(out_valid), 32'd1);
            check($sformatf("bp.stall%0d.redirect", c), 32'(redirect_valid), 32'd0);
            check($sformatf("bp.stall%0d.rpc", c),      redirect_pc, 32'h310);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_release", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp.b_valid",  32'(out_valid), 32'd1);
        check("bp.b_result", out_result, 32'd30);
        check("bp.b_pc",     out_pc, 32'h304);
        check("bp.b_rd",     32'(out_rd), 32'd4);
        $display("txn backpressure: A held 3 cycles, B result=0x%08h", out_result);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp.drain", 32'(out_valid), 32'd0);

        // Flush with a taken JAL registered and another JAL offered.
        @(negedge clk);
        out_ready = 1'b0;
        drive(BR_JAL, ALU_ADD, 32'h400, 32'h0, 32'h0, 32'h20, 0, 0, 5'd5);
        @(posedge clk);
        #1;
        check("fl.jal_redirect", 32'(redirect_valid), 32'd1);
        @(negedge clk);
        drive(BR_JAL, ALU_ADD, 32'h500, 32'h0, 32'h0, 32'h40, 0, 0, 5'd6);
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        check("fl.in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("fl.out_valid",  32'(out_valid), 32'd0);
        check("fl.redirect",   32'(redirect_valid), 32'd0);
        check("fl.misaligned", 32'(misaligned), 32'd0);
        $display("txn flush: out_valid=%0b redirect=%0b", out_valid, redirect_valid);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("fl.no_late_accept", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a stall.
        @(negedge clk);
        out_ready = 1'b0;
        drive(BR_JAL, ALU_ADD, 32'h600, 32'h0, 32'h0, 32'h10, 0, 0, 5'd7);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rs.stalled_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rs.async");
        @(posedge clk);
        #1;
        check_all_zero("rs.held");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(BR_NONE, ALU_ADD, 32'h700, 32'd5, 32'd7, 32'h0, 0, 0, 5'd8);
        @(posedge clk);
        #1;
        check("rs.first_valid",  32'(out_valid), 32'd1);
        check("rs.first_result", out_result, 32'd12);
        check("rs.first_pc",     out_pc, 32'h700);
        $display("txn reset_mid_stall: first accept result=0x%08h", out_result);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
